// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// control-bundle layout and the load-stall reload helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } hazard_state_e;

  // Packing order places branch at bit 10 down to alu_op at bits 2:0.
  typedef struct packed {
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_bundle_t;

  localparam int REMAIN_W = 3;

  function automatic logic [REMAIN_W-1:0] stall_reload(input int cycles);
    return REMAIN_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear/reload and async active-low clear.
// Clear together with increment loads the value 1.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_count <= WIDTH'(i_inc);
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: load-use stalls, EX redirects, data-memory wait
// freeze, saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IFID_rs1_i,
  input  logic [REG_ADDR_W-1:0] IFID_rs2_i,
  input  logic                  IFID_uses_rs1_i,
  input  logic                  IFID_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] IDEX_rd_i,
  input  logic                  IDEX_MemRead_i,
  input  logic                  redirect_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  output logic                  PCWrite_o,
  output logic                  IFIDWrite_o,
  output logic                  IFID_flush_o,
  output logic                  Ctrl_bubble_o,
  output logic                  pipe_hold_o,
  output logic                  mem_timeout_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]   TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [REMAIN_W-1:0] STALL_M1   = stall_reload(LOAD_STALL_CYCLES);

  hazard_state_e       r_state;
  hazard_state_e       w_state_next;
  logic [REMAIN_W-1:0] r_remain;
  logic [REMAIN_W-1:0] w_remain_next;
  logic                r_timeout;
  logic [WAIT_W-1:0]   w_wait_count;

  logic w_luh;
  logic w_mem_busy;
  logic w_run_eval;
  logic w_mem_check;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_flush;
  logic w_bubble;
  logic w_hold;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_wait_clr;
  logic w_wait_inc;
  logic w_timeout_set;

  assign w_luh = IDEX_MemRead_i && (IDEX_rd_i != {REG_ADDR_W{1'b0}}) &&
                 ((IFID_uses_rs1_i && (IFID_rs1_i == IDEX_rd_i)) ||
                  (IFID_uses_rs2_i && (IFID_rs2_i == IDEX_rd_i)));

  assign w_mem_busy = mem_req_i && !mem_ready_i;

  // Mealy next-state and pipeline-control decode.
  always_comb begin
    w_state_next  = r_state;
    w_remain_next = r_remain;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    w_hold        = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_wait_clr    = 1'b0;
    w_wait_inc    = 1'b0;
    w_run_eval    = 1'b0;
    w_mem_check   = 1'b0;

    case (r_state)
      ST_LOAD_STALL: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        if (w_mem_busy) begin
          w_hold = 1'b1;
        end else begin
          w_bubble      = 1'b1;
          w_stall_inc   = 1'b1;
          w_remain_next = r_remain - 3'd1;
          if (r_remain <= 3'd1) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_LOAD_STALL;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready_i) begin
          w_hold       = 1'b1;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_wait_inc   = 1'b1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      default: begin
        w_run_eval  = 1'b1;
        w_mem_check = 1'b1;
      end
    endcase

    // The ready cycle out of MEM_WAIT skips the memory-busy check.
    if (w_run_eval) begin
      if (w_mem_check && w_mem_busy) begin
        w_hold       = 1'b1;
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_wait_clr   = 1'b1;
        w_wait_inc   = 1'b1;
        w_state_next = ST_MEM_WAIT;
      end else if (redirect_i) begin
        w_flush      = 1'b1;
        w_bubble     = 1'b1;
        w_flush_inc  = 1'b1;
        w_state_next = ST_RUN;
      end else if (w_luh) begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_bubble     = 1'b1;
        w_stall_inc  = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          w_state_next  = ST_LOAD_STALL;
          w_remain_next = STALL_M1;
        end else begin
          w_state_next = ST_RUN;
        end
      end else begin
        w_state_next = ST_RUN;
      end
    end else begin
      w_mem_check = 1'b0;
    end
  end

  assign w_timeout_set = w_wait_clr ? (MEM_TIMEOUT <= 1)
                                    : (w_wait_inc && (w_wait_count >= TIMEOUT_M1));

  // State and stall-remain registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_remain <= 3'd0;
    end else begin
      r_state  <= w_state_next;
      r_remain <= w_remain_next;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_set) begin
      r_timeout <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (1'b0),
    .i_inc   (w_stall_inc),
    .o_count (stall_count_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (1'b0),
    .i_inc   (w_flush_inc),
    .o_count (flush_count_o)
  );

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_wait_clr),
    .i_inc   (w_wait_inc),
    .o_count (w_wait_count)
  );

  // While reset is low the pipeline sees a flushed, bubbled, non-advancing front end.
  assign PCWrite_o     = reset & w_pc_write;
  assign IFIDWrite_o   = reset & w_ifid_write;
  assign IFID_flush_o  = ~reset | w_flush;
  assign Ctrl_bubble_o = ~reset | w_bubble;
  assign pipe_hold_o   = reset & w_hold;
  assign mem_timeout_o = r_timeout;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed vector table,
// hand-written multi-cycle sequences and randomized cycles against a reference model.
module tb_hazard_detection_unit;

  localparam int RW  = 5;
  localparam int LSC = 2;
  localparam int MT  = 3;
  localparam int CW  = 16;
  localparam int NT  = 21;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic          u1 = 1'b0, u2 = 1'b0, mr = 1'b0, redir = 1'b0, req = 1'b0, rdy = 1'b0;
  logic          pcw, ifidw, flush, bub, hold, tmo;
  logic [CW-1:0] sc, fc;

  int n_vec = 0;
  int n_err = 0;

  hazard_detection_unit #(
    .REG_ADDR_W(RW), .LOAD_STALL_CYCLES(LSC), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
    .IFID_uses_rs1_i(u1), .IFID_uses_rs2_i(u2),
    .IDEX_rd_i(rd), .IDEX_MemRead_i(mr),
    .redirect_i(redir), .mem_req_i(req), .mem_ready_i(rdy),
    .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .IFID_flush_o(flush),
    .Ctrl_bubble_o(bub), .pipe_hold_o(hold), .mem_timeout_o(tmo),
    .stall_count_o(sc), .flush_count_o(fc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, redir, req, rdy;
  } stim_t;

  typedef struct packed {
    logic        pcw, ifidw, flush, bub, hold, tmo;
    logic [15:0] sc, fc;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  // Reference model: bubbles still owed, memory-wait flag and its cycle count.
  int m_left = 0;
  bit m_wait = 1'b0;
  int m_wcnt = 0;
  bit m_tmo  = 1'b0;
  int m_sc   = 0;
  int m_fc   = 0;

  function automatic stim_t st(int a, int b, bit ua, bit ub, int d, bit m, bit r, bit q, bit y);
    stim_t s;
    s.rs1 = 5'(a); s.rs2 = 5'(b); s.rd = 5'(d);
    s.u1 = ua; s.u2 = ub; s.mr = m; s.redir = r; s.req = q; s.rdy = y;
    return s;
  endfunction

  function automatic obs_t ob(bit p, bit i, bit f, bit b, bit h, bit t, int s, int c);
    obs_t o;
    o.pcw = p; o.ifidw = i; o.flush = f; o.bub = b; o.hold = h; o.tmo = t;
    o.sc = 16'(s); o.fc = 16'(c);
    return o;
  endfunction

  function automatic int sat16(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step(input stim_t s, output obs_t e);
    bit luh, busy;
    luh  = s.mr && (s.rd != 5'd0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    busy = s.req && !s.rdy;
    e = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_tmo, m_sc, m_fc);
    if (m_left > 0) begin
      if (busy) e.hold = 1'b1;
      else begin
        e.bub = 1'b1; m_sc = sat16(m_sc + 1); m_left = m_left - 1;
      end
    end else if (m_wait && !s.rdy) begin
      e.hold = 1'b1; m_wcnt = m_wcnt + 1;
      if (m_wcnt >= MT) m_tmo = 1'b1;
    end else if (!m_wait && busy) begin
      e.hold = 1'b1; m_wait = 1'b1; m_wcnt = 1;
      if (m_wcnt >= MT) m_tmo = 1'b1;
    end else begin
      m_wait = 1'b0;
      if (s.redir) begin
        e.pcw = 1'b1; e.ifidw = 1'b1; e.flush = 1'b1; e.bub = 1'b1;
        m_fc = sat16(m_fc + 1);
      end else if (luh) begin
        e.bub = 1'b1; m_sc = sat16(m_sc + 1); m_left = LSC - 1;
      end else begin
        e.pcw = 1'b1; e.ifidw = 1'b1;
      end
    end
  endtask

  task automatic check(input string nm, input obs_t e);
    obs_t a;
    a = {pcw, ifidw, flush, bub, hold, tmo, sc, fc};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got pc=%b ifid=%b flush=%b bub=%b hold=%b tmo=%b stall=%0d flushes=%0d; want pc=%b ifid=%b flush=%b bub=%b hold=%b tmo=%b stall=%0d flushes=%0d",
               nm, a.pcw, a.ifidw, a.flush, a.bub, a.hold, a.tmo, a.sc, a.fc,
               e.pcw, e.ifidw, e.flush, e.bub, e.hold, e.tmo, e.sc, e.fc);
    end
  endtask

  task automatic apply(input stim_t s, output obs_t e);
    @(negedge clk);
    rs1 = s.rs1; rs2 = s.rs2; rd = s.rd;
    u1 = s.u1; u2 = s.u2; mr = s.mr; redir = s.redir; req = s.req; rdy = s.rdy;
    #1;
    model_step(s, e);
  endtask

  // Async reset asserted mid-cycle; the release cycle runs idle inputs, which leave RUN unchanged.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    u1 = 1'b0; u2 = 1'b0; mr = 1'b0; redir = 1'b0; req = 1'b0; rdy = 1'b0;
    #1;
    check("reset_forced", ob(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
    m_left = 0; m_wait = 1'b0; m_wcnt = 0; m_tmo = 1'b0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  tbl [NT];
    obs_t  me;
    stim_t idle, luh1, busy;
    idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    luh1 = st(5, 0, 1, 0, 5, 1, 0, 0, 0);
    busy = st(0, 0, 0, 0, 0, 0, 0, 1, 0);

    tbl[0]  = '{idle,                          ob(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{luh1,                          ob(0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[2]  = '{idle,                          ob(0, 0, 0, 1, 0, 0, 1, 0)};
    tbl[3]  = '{idle,                          ob(1, 1, 0, 0, 0, 0, 2, 0)};
    tbl[4]  = '{st(0, 0, 1, 0, 0, 1, 0, 0, 0), ob(1, 1, 0, 0, 0, 0, 2, 0)};
    tbl[5]  = '{st(5, 0, 0, 0, 5, 1, 0, 0, 0), ob(1, 1, 0, 0, 0, 0, 2, 0)};
    tbl[6]  = '{st(0, 7, 0, 1, 7, 1, 0, 0, 0), ob(0, 0, 0, 1, 0, 0, 2, 0)};
    tbl[7]  = '{busy,                          ob(0, 0, 0, 0, 1, 0, 3, 0)};
    tbl[8]  = '{idle,                          ob(0, 0, 0, 1, 0, 0, 3, 0)};
    tbl[9]  = '{st(5, 0, 1, 0, 5, 1, 1, 0, 0), ob(1, 1, 1, 1, 0, 0, 4, 0)};
    tbl[10] = '{busy,                          ob(0, 0, 0, 0, 1, 0, 4, 1)};
    tbl[11] = '{busy,                          ob(0, 0, 0, 0, 1, 0, 4, 1)};
    tbl[12] = '{busy,                          ob(0, 0, 0, 0, 1, 0, 4, 1)};
    tbl[13] = '{busy,                          ob(0, 0, 0, 0, 1, 1, 4, 1)};
    tbl[14] = '{st(5, 0, 1, 0, 5, 1, 0, 1, 1), ob(0, 0, 0, 1, 0, 1, 4, 1)};
    tbl[15] = '{idle,                          ob(0, 0, 0, 1, 0, 1, 5, 1)};
    tbl[16] = '{idle,                          ob(1, 1, 0, 0, 0, 1, 6, 1)};
    tbl[17] = '{st(0, 0, 0, 0, 0, 0, 0, 1, 1), ob(1, 1, 0, 0, 0, 1, 6, 1)};
    tbl[18] = '{busy,                          ob(0, 0, 0, 0, 1, 1, 6, 1)};
    tbl[19] = '{st(0, 0, 0, 0, 0, 0, 1, 0, 1), ob(1, 1, 1, 1, 0, 1, 6, 1)};
    tbl[20] = '{idle,                          ob(1, 1, 0, 0, 0, 1, 6, 2)};

    do_reset();
    for (int i = 0; i < NT; i++) begin
      apply(tbl[i].s, me);
      check($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Five hold cycles, then a ready cycle with a load-use pending behind the freeze.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(busy, me);
      check($sformatf("hold%0d", k), ob(0, 0, 0, 0, 1, (k >= 3), 0, 0));
    end
    apply(st(5, 0, 1, 0, 5, 1, 0, 1, 1), me);
    check("hold_ready_luh", ob(0, 0, 0, 1, 0, 1, 0, 0));
    apply(idle, me);
    check("hold_stall2", ob(0, 0, 0, 1, 0, 1, 1, 0));
    apply(idle, me);
    check("hold_resume", ob(1, 1, 0, 0, 0, 1, 2, 0));

    // Reset arriving during LOAD_STALL abandons the stall.
    do_reset();
    apply(luh1, me);
    check("rst_ls_enter", ob(0, 0, 0, 1, 0, 0, 0, 0));
    do_reset();
    apply(idle, me);
    check("rst_ls_run", ob(1, 1, 0, 0, 0, 0, 0, 0));
    apply(luh1, me);
    check("rst_ls_luh", ob(0, 0, 0, 1, 0, 0, 0, 0));
    apply(idle, me);
    check("rst_ls_b2", ob(0, 0, 0, 1, 0, 0, 1, 0));
    apply(idle, me);
    check("rst_ls_done", ob(1, 1, 0, 0, 0, 0, 2, 0));

    // Randomized cycles against the reference model, with occasional reset pulses.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      stim_t s;
      if ($urandom_range(0, 149) == 0) do_reset();
      s = st($urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 4) < 3));
      apply(s, me);
      check($sformatf("rand%0d", n), me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
